// File: rtl/pipe_skid_stage.sv
// Pipeline boundary register with a valid/ready handshake and a two-entry skid buffer.
// in_ready depends only on registered state, flush and rst, so downstream stalls never form a combinational path upstream.
module pipe_skid_stage #(
  // Default packing MSB..LSB: pc_branch[31:0], alu_zero, alu_result[31:0], read_data2[31:0], reg_dest[4:0]
  parameter int unsigned DATA_W     = 102,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  // State encoding is {main_v, skid_v}; 2'b01 is illegal.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_q,   main_d;
  logic [DATA_W-1:0] skid_q,   skid_d;
  logic              push, pop;

  assign in_ready  = !skid_v_q && !flush && !rst;
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign count     = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign push      = in_valid && in_ready;
  assign pop       = main_v_q && out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (rst) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = '0;
      skid_d   = '0;
    end else if (flush) begin
      // A pop in this cycle has already completed; only the held entries are discarded.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case ({main_v_q, skid_v_q})
        EMPTY: begin
          if (push) begin
            main_v_d = 1'b1;
            main_d   = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_v_d = 1'b1;
            skid_d   = in_data;
          end else if (pop) begin
            main_v_d = 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so the only move is draining skid into main.
          if (pop) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    main_v_q <= main_v_d;
    skid_v_q <= skid_v_d;
    main_q   <= main_d;
    skid_q   <= skid_d;
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboarded checks for pipe_skid_stage, with CLEAR_DATA=1 and CLEAR_DATA=0 instances.
module tb_pipe_skid_stage;
  localparam int W = 102;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  logic         flush0, in_valid0, out_ready0;
  logic [W-1:0] in_data0;
  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   count0;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] prev_data;
  logic [127:0] rnd;
  logic         stall;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(W), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_skid_stage #(.DATA_W(W), .CLEAR_DATA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .count(count0)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = '1; out_ready = 1'b0;
    flush0 = 1'b0; in_valid0 = 1'b1; in_data0 = '1; out_ready0 = 1'b0;

    // Reset held two cycles with an all-ones offer
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_data", out_data, W'(0));
      chk("rst_count", W'(count), W'(0));
      chk("rst_in_ready", W'(in_ready), W'(0));
      chk("rst_out_data0", out_data0, W'(0));
    end
    rst = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
    #1;
    chk("rel_in_ready", W'(in_ready), W'(1));

    // Streaming with downstream always ready
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = W'(i);
      tick();
      chk("stream_data", out_data, W'(i));
      chk("stream_valid", W'(out_valid), W'(1));
      chk("stream_count", W'(count), W'(1));
      chk("stream_in_ready", W'(in_ready), W'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", W'(out_valid), W'(0));
    chk("stream_drain_count", W'(count), W'(0));

    // Stall fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'hAA);
    tick();
    chk("stall1_count", W'(count), W'(1));
    chk("stall1_data", out_data, W'(8'hAA));
    in_data = W'(8'hBB);
    tick();
    chk("stall2_count", W'(count), W'(2));
    chk("stall2_in_ready", W'(in_ready), W'(0));
    chk("stall2_data", out_data, W'(8'hAA));
    in_valid = 1'b0;
    tick();
    chk("stall_hold_data", out_data, W'(8'hAA));
    chk("stall_hold_count", W'(count), W'(2));
    out_ready = 1'b1;
    tick();
    chk("drain_data", out_data, W'(8'hBB));
    chk("drain_count", W'(count), W'(1));
    chk("drain_in_ready", W'(in_ready), W'(1));
    tick();
    chk("drain_empty", W'(out_valid), W'(0));

    // Flush while FULL with a same-cycle offer
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h11);
    tick();
    in_data = W'(8'h22);
    tick();
    chk("pre_flush_count", W'(count), W'(2));
    flush = 1'b1; in_data = W'(8'h55);
    #1;
    chk("flush_in_ready", W'(in_ready), W'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", W'(count), W'(0));
    chk("flush_valid", W'(out_valid), W'(0));
    chk("flush_data", out_data, W'(0));
    out_ready = 1'b1;
    tick();
    chk("flush_no_55", W'(out_valid), W'(0));

    // Flush with CLEAR_DATA=0 keeps the payload register contents
    in_valid0 = 1'b1; in_data0 = W'(8'h77);
    tick();
    in_valid0 = 1'b0;
    chk("cd0_load", out_data0, W'(8'h77));
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    chk("cd0_flush_valid", W'(out_valid0), W'(0));
    chk("cd0_flush_data", out_data0, W'(8'h77));
    chk("cd0_flush_count", W'(count0), W'(0));
    in_valid0 = 1'b1; in_data0 = W'(8'h88);
    tick();
    in_valid0 = 1'b0;
    chk("cd0_next_valid", W'(out_valid0), W'(1));
    chk("cd0_next_data", out_data0, W'(8'h88));

    // Random valid/ready/flush against an ordered scoreboard
    sb.delete();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      rnd       = {$urandom, $urandom, $urandom, $urandom};
      in_data   = rnd[W-1:0];
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("rand_spurious_pop", W'(1), W'(0));
        else begin
          chk("rand_order", out_data, sb[0]);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (flush) sb.delete();
      stall = out_valid && !out_ready && !flush;
      prev_data = out_data;
      tick();
      if (stall) chk("rand_stable", out_data, prev_data);
      chk("rand_count", W'(count), W'(sb.size()));
      chk("rand_legal_state", W'(out_valid), W'(count != 2'd0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
